// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg: shared types and constants for the truth-table sweeper.
//   sweep_state_e : FSM state encoding (IDLE, DRIVE, SAMPLE, DONE)
//   SETTLE_MAX    : largest supported per-vector hold time in cycles
//   settle_load() : clamps a SETTLE value to 1..SETTLE_MAX and returns the
//                   hold-timer preload (SETTLE-1)
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StSample,
        StDone
    } sweep_state_e;

    localparam int unsigned SETTLE_MAX = 15;
    localparam int unsigned SETTLE_W   = $clog2(SETTLE_MAX + 1);

    function automatic logic [SETTLE_W-1:0] settle_load(input int unsigned settle);
        logic [SETTLE_W-1:0] r;
        if (settle < 1) begin
            r = '0;
        end else if (settle > SETTLE_MAX) begin
            r = SETTLE_W'(SETTLE_MAX - 1);
        end else begin
            r = SETTLE_W'(settle - 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// tt_settle_timer: hold counter for the DRIVE phase of tt_sweep.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   load_i    : pulse in the cycle the FSM is about to enter DRIVE
//   run_i     : high while the FSM is in DRIVE
//   expired_o : high in the last DRIVE cycle (after SETTLE cycles in DRIVE)
module tt_settle_timer
    import tt_sweep_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic run_i,
    output logic expired_o
);

    localparam logic [SETTLE_W-1:0] LoadVal = settle_load(SETTLE);
    localparam logic [SETTLE_W-1:0] CntOne  = SETTLE_W'(1);

    logic [SETTLE_W-1:0] cnt_q, cnt_d;

    // Preload SETTLE-1 so a count of zero marks the final DRIVE cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LoadVal;
        end else if (run_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CntOne;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/tt_sweep.sv
// tt_sweep: exhaustively drives every N-bit input vector to two functions
// under test and compares their outputs, reporting mismatch count, the first
// failing vector and an equivalence flag.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   start, abort        : begin a sweep (IDLE only) / cancel a running sweep
//   vec_o               : input combination driven to both functions
//   fa_i, fb_i          : outputs of the two functions under comparison
//   busy, done          : sweep running (DRIVE/SAMPLE) / one-cycle completion
//   equiv               : last completed sweep had zero mismatches
//   mismatch_cnt        : mismatching vectors in the current/last sweep
//   first_fail          : lowest mismatching vector, valid when fail_valid
// Optional build macro TT_SWEEP_DONTCARE_EN adds input dc_mask[2^N-1:0];
// a mismatch at vector v is ignored when dc_mask[v] is set. Timing is
// identical either way.
module tt_sweep
    import tt_sweep_pkg::*;
#(
    parameter int unsigned N      = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
`ifdef TT_SWEEP_DONTCARE_EN
    input  logic [2**N-1:0] dc_mask,
`endif
    input  logic          fa_i,
    input  logic          fb_i,
    output logic [N-1:0]  vec_o,
    output logic          busy,
    output logic          done,
    output logic          equiv,
    output logic [N:0]    mismatch_cnt,
    output logic [N-1:0]  first_fail,
    output logic          fail_valid
);

    localparam logic [N-1:0] VecOne = N'(1);
    localparam logic [N-1:0] VecMax = '1;

    sweep_state_e state_q;
    logic [N-1:0] vec_q;
    logic [N:0]   cnt_q;
    logic [N-1:0] first_fail_q;
    logic         fail_valid_q;
    logic         equiv_q;

    logic         vec_last;
    logic         sample_mis;
    logic [N:0]   cnt_d;
    logic         timer_load;
    logic         timer_expired;

    assign vec_last = (vec_q == VecMax);

`ifdef TT_SWEEP_DONTCARE_EN
    assign sample_mis = (fa_i ^ fb_i) & ~dc_mask[vec_q];
`else
    assign sample_mis = fa_i ^ fb_i;
`endif

    // Count including the vector being sampled; equals cnt_q when it matched.
    assign cnt_d = cnt_q + {{N{1'b0}}, sample_mis};

    // Load the hold timer on every transition into DRIVE.
    assign timer_load = ((state_q == StIdle) && start && !abort) ||
                        ((state_q == StSample) && !abort && !vec_last);

    tt_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (timer_load),
        .run_i     (state_q == StDrive),
        .expired_o (timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            vec_q        <= '0;
            cnt_q        <= '0;
            first_fail_q <= '0;
            fail_valid_q <= 1'b0;
            equiv_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // abort wins over a same-cycle start
                    if (start && !abort) begin
                        state_q      <= StDrive;
                        vec_q        <= '0;
                        cnt_q        <= '0;
                        first_fail_q <= '0;
                        fail_valid_q <= 1'b0;
                        equiv_q      <= 1'b0;
                    end
                end
                StDrive: begin
                    if (abort) begin
                        state_q <= StIdle;
                        equiv_q <= 1'b0;
                    end else if (timer_expired) begin
                        state_q <= StSample;
                    end
                end
                StSample: begin
                    if (abort) begin
                        state_q <= StIdle;
                        equiv_q <= 1'b0;
                    end else begin
                        if (sample_mis) begin
                            cnt_q <= cnt_d;
                            if (!fail_valid_q) begin
                                first_fail_q <= vec_q;
                                fail_valid_q <= 1'b1;
                            end
                        end
                        if (vec_last) begin
                            state_q <= StDone;
                            equiv_q <= (cnt_d == '0);
                        end else begin
                            vec_q   <= vec_q + VecOne;
                            state_q <= StDrive;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign vec_o        = vec_q;
    assign busy         = (state_q == StDrive) || (state_q == StSample);
    assign done         = (state_q == StDone);
    assign equiv        = equiv_q;
    assign mismatch_cnt = cnt_q;
    assign first_fail   = first_fail_q;
    assign fail_valid   = fail_valid_q;

endmodule

// File: tb/tb_tt_sweep.sv
// tb_tt_sweep: directed self-checking bench for tt_sweep. Instance A uses
// N=3/SETTLE=1 comparing an SOP function against its POS form; instance B
// uses N=4/SETTLE=3 with a parity function. Expected sweep results are
// computed by a reference model, queued when a sweep is launched and popped
// when the done pulse arrives.
module tb_tt_sweep;

    typedef struct {
        int         lat;
        logic       equiv;
        logic [4:0] cnt;
        logic [3:0] ff;
        logic       fv;
    } exp_t;

    typedef struct {
        logic [3:0] vec;
        logic       busy;
        logic       done;
        logic       equiv;
        logic [4:0] cnt;
        logic [3:0] ff;
        logic       fv;
    } obs_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: N=3, SETTLE=1
    logic       a_start = 1'b0, a_abort = 1'b0;
    logic       a_fa, a_fb;
    logic [2:0] a_vec;
    logic       a_busy, a_done, a_equiv, a_fv;
    logic [3:0] a_cnt;
    logic [2:0] a_ff;
    int         a_mode = 0;

    // Instance B: N=4, SETTLE=3
    logic       b_start = 1'b0, b_abort = 1'b0;
    logic       b_fa, b_fb;
    logic [3:0] b_vec;
    logic       b_busy, b_done, b_equiv, b_fv;
    logic [4:0] b_cnt;
    logic [3:0] b_ff;
    int         b_mode = 0;

`ifdef TT_SWEEP_DONTCARE_EN
    logic [7:0]  a_dc = '0;
    logic [15:0] b_dc = '0;
`endif

    // f1 = ac' + bc + b'c' with {a,b,c} = vec[2:0]
    function automatic logic f_sop(input logic [2:0] v);
        return (v[2] & ~v[0]) | (v[1] & v[0]) | (~v[1] & ~v[0]);
    endfunction

    function automatic logic f_pos(input logic [2:0] v);
        return (v[0] | v[2] | ~v[1]) & (~v[0] | v[1]);
    endfunction

    function automatic logic a_fb_f(input logic [2:0] v, input int mode);
        logic r;
        r = f_pos(v);
        if (mode == 1 && v == 3'd5) r = ~r;
        return r;
    endfunction

    function automatic logic b_fa_f(input logic [3:0] v);
        return ^v;
    endfunction

    function automatic logic b_fb_f(input logic [3:0] v, input int mode);
        if (mode == 0) return ~b_fa_f(v);
        return b_fa_f(v) ^ (v == 4'd0 || v == 4'd2 || v == 4'd5 || v == 4'd11);
    endfunction

    assign a_fa = f_sop(a_vec);
    assign a_fb = a_fb_f(a_vec, a_mode);
    assign b_fa = b_fa_f(b_vec);
    assign b_fb = b_fb_f(b_vec, b_mode);

    tt_sweep #(
        .N      (3),
        .SETTLE (1)
    ) u_dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (a_start),
        .abort        (a_abort),
`ifdef TT_SWEEP_DONTCARE_EN
        .dc_mask      (a_dc),
`endif
        .fa_i         (a_fa),
        .fb_i         (a_fb),
        .vec_o        (a_vec),
        .busy         (a_busy),
        .done         (a_done),
        .equiv        (a_equiv),
        .mismatch_cnt (a_cnt),
        .first_fail   (a_ff),
        .fail_valid   (a_fv)
    );

    tt_sweep #(
        .N      (4),
        .SETTLE (3)
    ) u_dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (b_start),
        .abort        (b_abort),
`ifdef TT_SWEEP_DONTCARE_EN
        .dc_mask      (b_dc),
`endif
        .fa_i         (b_fa),
        .fb_i         (b_fb),
        .vec_o        (b_vec),
        .busy         (b_busy),
        .done         (b_done),
        .equiv        (b_equiv),
        .mismatch_cnt (b_cnt),
        .first_fail   (b_ff),
        .fail_valid   (b_fv)
    );

    function automatic obs_t obs(input int sel);
        obs_t o;
        if (sel == 1) begin
            o.vec = b_vec; o.busy = b_busy; o.done = b_done; o.equiv = b_equiv;
            o.cnt = b_cnt; o.ff = b_ff; o.fv = b_fv;
        end else begin
            o.vec = {1'b0, a_vec}; o.busy = a_busy; o.done = a_done; o.equiv = a_equiv;
            o.cnt = {1'b0, a_cnt}; o.ff = {1'b0, a_ff}; o.fv = a_fv;
        end
        return o;
    endfunction

    // Reference model of one full sweep.
    function automatic exp_t model(input int sel, input int mode);
        exp_t e;
        int   nv;
        int   settle;
        logic mis;
        nv     = (sel == 1) ? 16 : 8;
        settle = (sel == 1) ? 3 : 1;
        e.cnt  = '0;
        e.ff   = '0;
        e.fv   = 1'b0;
        for (int v = 0; v < nv; v++) begin
            if (sel == 1) mis = b_fa_f(4'(v)) != b_fb_f(4'(v), mode);
            else          mis = f_sop(3'(v)) != a_fb_f(3'(v), mode);
`ifdef TT_SWEEP_DONTCARE_EN
            if (sel == 1 && b_dc[v]) mis = 1'b0;
`endif
            if (mis) begin
                e.cnt = e.cnt + 5'd1;
                if (!e.fv) begin
                    e.ff = 4'(v);
                    e.fv = 1'b1;
                end
            end
        end
        e.equiv = (e.cnt == 5'd0);
        e.lat   = nv * (settle + 1);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input int sel, input string tag);
        obs_t o;
        o = obs(sel);
        chk({tag, ".vec"},   32'(o.vec),   32'd0);
        chk({tag, ".busy"},  32'(o.busy),  32'd0);
        chk({tag, ".done"},  32'(o.done),  32'd0);
        chk({tag, ".equiv"}, 32'(o.equiv), 32'd0);
        chk({tag, ".cnt"},   32'(o.cnt),   32'd0);
        chk({tag, ".ff"},    32'(o.ff),    32'd0);
        chk({tag, ".fv"},    32'(o.fv),    32'd0);
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 1) b_start = v; else a_start = v;
    endtask

    // Launch one sweep, optionally re-pulsing start while busy, and score it.
    task automatic sweep(input int sel, input string tag, input int mode, input bit poke);
        exp_t e;
        obs_t o;
        int   lat;
        if (sel == 1) b_mode = mode; else a_mode = mode;
        sb.push_back(model(sel, mode));
        @(negedge clk);
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        o = obs(sel);
        chk({tag, ".acc_busy"},  32'(o.busy),  32'd1);
        chk({tag, ".acc_vec"},   32'(o.vec),   32'd0);
        chk({tag, ".acc_cnt"},   32'(o.cnt),   32'd0);
        chk({tag, ".acc_fv"},    32'(o.fv),    32'd0);
        chk({tag, ".acc_equiv"}, 32'(o.equiv), 32'd0);
        lat = 0;
        while (!obs(sel).done && lat < 200) begin
            @(negedge clk);
            lat++;
            if (poke && lat == 5) set_start(sel, 1'b1);
            if (poke && lat == 7) set_start(sel, 1'b0);
        end
        e = sb.pop_front();
        o = obs(sel);
        chk({tag, ".latency"}, 32'(lat),     32'(e.lat));
        chk({tag, ".equiv"},   32'(o.equiv), 32'(e.equiv));
        chk({tag, ".cnt"},     32'(o.cnt),   32'(e.cnt));
        chk({tag, ".ff"},      32'(o.ff),    32'(e.ff));
        chk({tag, ".fv"},      32'(o.fv),    32'(e.fv));
        @(negedge clk);
        o = obs(sel);
        chk({tag, ".done_pulse"}, 32'(o.done), 32'd0);
        chk({tag, ".idle_busy"},  32'(o.busy), 32'd0);
        @(negedge clk);
        o = obs(sel);
        chk({tag, ".hold_vec"},   32'(o.vec),   (sel == 1) ? 32'd15 : 32'd7);
        chk({tag, ".hold_cnt"},   32'(o.cnt),   32'(e.cnt));
        chk({tag, ".hold_equiv"}, 32'(o.equiv), 32'(e.equiv));
    endtask

    initial begin
        int lat;
        int ndone;

        // Reset values while rst_n is held low
        #12;
        chk_reset(0, "rst_a");
        chk_reset(1, "rst_b");
        @(negedge clk);
        rst_n = 1'b1;

        sweep(0, "eq3", 0, 1'b0);
        sweep(0, "flip5", 1, 1'b0);
        sweep(1, "inv4", 0, 1'b0);
        sweep(0, "busy_start", 0, 1'b1);

        // Abort at vec_o=2: back to IDLE, equiv cleared, no done pulse
        a_mode = 0;
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        lat = 0;
        while (a_vec != 3'd2 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("abort.reach_vec2", 32'(a_vec), 32'd2);
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        chk("abort.busy",  32'(a_busy),  32'd0);
        chk("abort.equiv", 32'(a_equiv), 32'd0);
        chk("abort.vec",   32'(a_vec),   32'd2);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_done) ndone++;
        end
        chk("abort.no_done", 32'(ndone), 32'd0);
        sweep(0, "after_abort", 0, 1'b0);

        // abort beats a same-cycle start in IDLE
        @(negedge clk);
        a_start = 1'b1;
        a_abort = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        a_abort = 1'b0;
        chk("abort_start.busy", 32'(a_busy), 32'd0);

        // Mismatches only at vectors 0,2,5,11 (masked when don't-cares exist)
`ifdef TT_SWEEP_DONTCARE_EN
        b_dc = 16'h0825;
`endif
        sweep(1, "dc4", 1, 1'b0);

        // Reset mid-sweep after a mismatch has been recorded
        a_mode = 1;
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        lat = 0;
        while (a_vec != 3'd7 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("midrst.pre_fv", 32'(a_fv), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset(0, "midrst_a");
        @(negedge clk);
        rst_n = 1'b1;
        sweep(0, "post_rst", 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tt_sweep.md
TT_SWEEP -- requirements
Module: tt_sweep

Interface
REQ-001 SHALL have parameter N, default 4: width of the input vector driven to the function pair under test.
REQ-002 SHALL have parameter SETTLE, default 1 (legal 1..15): cycles each vector is held before the outputs are sampled.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: request a full sweep; accepted only in IDLE.
REQ-006 SHALL have port abort, input, 1: cancel a sweep in progress.
REQ-007 SHALL have port vec_o, output, N: current input combination driven to both functions under test.
REQ-008 SHALL have ports fa_i and fb_i, input, 1 each: outputs of the two functions being compared.
REQ-009 SHALL have port busy, output, 1: high in DRIVE and SAMPLE.
REQ-010 SHALL have port done, output, 1: one-cycle pulse when a sweep completes.
REQ-011 SHALL have port equiv, output, 1: high when the last completed sweep found zero mismatches.
REQ-012 SHALL have port mismatch_cnt, output, N+1: number of mismatching vectors in the current or last sweep.
REQ-013 SHALL have port first_fail, output, N: lowest vector that mismatched.
REQ-014 SHALL have port fail_valid, output, 1: first_fail holds a valid value.

Function
REQ-015 SHALL implement the FSM states IDLE, DRIVE, SAMPLE and DONE.
REQ-016 IDLE with start=1 SHALL, on the next edge, set vec_o=0, mismatch_cnt=0, fail_valid=0, first_fail=0 and equiv=0, and go to DRIVE.
REQ-017 DRIVE SHALL last exactly SETTLE cycles with vec_o stable, then go to SAMPLE.
REQ-018 SAMPLE SHALL last one cycle and compare fa_i with fb_i at the edge leaving SAMPLE.
REQ-019 On a SAMPLE mismatch, mismatch_cnt SHALL increment; if fail_valid=0, first_fail SHALL be set to vec_o and fail_valid to 1.
REQ-020 Leaving SAMPLE with vec_o below 2^N-1, vec_o SHALL increment and the FSM return to DRIVE; at 2^N-1 the FSM SHALL go to DONE without wrapping vec_o.
REQ-021 DONE SHALL assert done for one cycle, set equiv=(mismatch_cnt==0) including the final sample, and return to IDLE.
REQ-022 Start-accept to the done pulse SHALL take exactly 2^N*(SETTLE+1) cycles.
REQ-023 mismatch_cnt SHALL be N+1 bits wide, so no saturation is needed (maximum 2^N).
REQ-024 start while busy or in DONE SHALL be ignored.
REQ-025 abort in DRIVE or SAMPLE SHALL return the FSM to IDLE next edge, without a done pulse, and clear equiv.
REQ-026 abort SHALL take priority over a same-cycle SAMPLE update and over a same-cycle start.
REQ-027 In IDLE, vec_o, mismatch_cnt, first_fail, fail_valid and equiv SHALL hold their last values.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, vec_o=0, busy=0, done=0, equiv=0, mismatch_cnt=0, first_fail=0 and fail_valid=0, including mid-sweep.
REQ-029 After rst_n deasserts, the first start SHALL be accepted no earlier than the first rising edge.

Configuration
REQ-030 With macro TT_SWEEP_DONTCARE_EN defined, the block SHALL add input dc_mask, width 2^N; a mismatch at vector v SHALL be ignored when dc_mask[v]=1.
REQ-031 Without TT_SWEEP_DONTCARE_EN, the port SHALL be absent and every vector SHALL be compared.
REQ-032 Cycle timing SHALL be identical with and without TT_SWEEP_DONTCARE_EN.

Structure
REQ-033 Package tt_sweep_pkg SHALL hold the FSM state enum and the SETTLE_MAX=15 constant.
REQ-034 Sub-module tt_settle_timer SHALL implement the DRIVE hold counter: load on DRIVE entry, expire after SETTLE cycles.

Verification
REQ-035 N=3, SETTLE=1, f1=ac'+bc+b'c' vs its POS form: start -> done after 16 cycles, equiv=1, mismatch_cnt=0, fail_valid=0.
REQ-036 N=3, fb_i inverted only at vec 5: equiv=0, mismatch_cnt=1, first_fail=5, fail_valid=1.
REQ-037 N=4, SETTLE=3, fb_i=~fa_i: done after 64 cycles, mismatch_cnt=16, first_fail=0.
REQ-038 abort at vec_o=2, then start: no done pulse, equiv=0, then a clean full sweep; rst_n pulsed mid-sweep -> all outputs at reset values.
REQ-039 start asserted while busy: no restart and done timing unchanged.
REQ-040 With TT_SWEEP_DONTCARE_EN, N=4 and dc_mask bits 0,2,5,11 set, mismatches only at those vectors: equiv=1, mismatch_cnt=0.
